mult4_seq_pp_scheduler: RTL

//   Sequential 4x4 unsigned multiplier controller that time-shares ONE external 2x2 multiplier

---
 rtl/mult4_seq_pp_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mult4_seq_pp_scheduler.sv
// Sequential 4x4 unsigned multiplier that time-shares one external 2x2 core over four partial products.
// Latency 4*(1+MUL_LAT) cycles from accept to out_valid; no overlap, holds P/out_valid until out_ready.
module mult4_seq_pp_scheduler #(
    parameter int MUL_LAT = 0,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         A,
    input  logic [3:0]         B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         P,
    output logic [1:0]         mul_a,
    output logic [1:0]         mul_b,
    input  logic [3:0]         mul_p,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               r_state;
    logic [1:0]           r_step;
    logic                 r_sub;
    logic [3:0]           r_a;
    logic [3:0]           r_b;
    logic [7:0]           r_acc;
    logic [7:0]           r_p;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [1:0]           r_mul_a;
    logic [1:0]           r_mul_b;
    logic [COUNT_W-1:0]   r_count;

    logic                 w_last_sub;
    logic [2:0]           w_shift;
    logic [7:0]           w_pp;
    logic [7:0]           w_acc_next;
    logic [1:0]           w_next_step;

    // A step spans one cycle for a combinational core, two for a registered one.
    assign w_last_sub  = (r_sub == 1'(MUL_LAT));
    assign w_next_step = r_step + 2'd1;

    always_comb begin
        w_shift = 3'd0;
        case (r_step)
            2'd0:    w_shift = 3'd0;
            2'd1:    w_shift = 3'd2;
            2'd2:    w_shift = 3'd2;
            default: w_shift = 3'd4;
        endcase
    end

    assign w_pp       = {4'b0000, mul_p} << w_shift;
    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_sub       <= 1'b0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_acc       <= 8'd0;
            r_p         <= 8'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_mul_a     <= 2'd0;
            r_mul_b     <= 2'd0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= 8'd0;
                        r_step  <= 2'd0;
                        r_sub   <= 1'b0;
                        r_mul_a <= A[1:0];
                        r_mul_b <= B[1:0];
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!w_last_sub) begin
                        r_sub <= 1'b1;
                    end else begin
                        r_sub <= 1'b0;
                        r_acc <= w_acc_next;
                        if (r_step == 2'd3) begin
                            r_p         <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_mul_a     <= 2'd0;
                            r_mul_b     <= 2'd0;
                            r_state     <= S_DONE;
                        end else begin
                            // Operands for the next step are registered so they are stable all step long.
                            r_step  <= w_next_step;
                            r_mul_a <= w_next_step[1] ? r_a[3:2] : r_a[1:0];
                            r_mul_b <= w_next_step[0] ? r_b[3:2] : r_b[1:0];
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_count     <= r_count + COUNT_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign P         = r_p;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = r_busy;
    assign op_count  = r_count;
endmodule
